// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: sequencer states, special
// instructions, opcodes and instruction field positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] HALT = 16'h3FFF;

  localparam logic [1:0] OP_ALU1 = 2'b01;
  localparam logic [1:0] OP_ALU2 = 2'b10;
  localparam logic [1:0] OP_BR   = 2'b11;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 14;
  localparam int unsigned RS1_MSB = 13;
  localparam int unsigned RS1_LSB = 11;
  localparam int unsigned RS2_MSB = 10;
  localparam int unsigned RS2_LSB = 8;
  localparam int unsigned RD_MSB  = 7;
  localparam int unsigned RD_LSB  = 5;
  localparam int unsigned TGT_MSB = 7;
  localparam int unsigned TGT_LSB = 0;

  function automatic logic [1:0] opcode(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// Instruction-memory and hazard-controller bus of the pipe sequencer.
interface pipe_sequencer_if #(
  parameter int unsigned PC_W = 8
) ();
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            dhazard;
  logic            chazard;
  logic [15:0]     ifir;
  logic [15:0]     idir;
  logic [15:0]     exir;

  modport master (
    output imem_addr, ifir, idir, exir,
    input  imem_data, dhazard, chazard
  );

  modport slave (
    input  imem_addr, ifir, idir, exir,
    output imem_data, dhazard, chazard
  );
endinterface

// File: rtl/pipe_sequencer_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/pipe_sequencer.sv
// Program counter, IF/ID/EX instruction registers and start/halt/drain
// lifecycle for the 16-bit RISC pipeline, with stall/flush statistics.
module pipe_sequencer #(
  parameter int unsigned PC_W = 8,
  parameter logic [15:0] NOP  = pipe_pkg::NOP,
  parameter logic [15:0] HALT = pipe_pkg::HALT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  pipe_sequencer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);
  import pipe_pkg::*;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ifir, idir, exir;
  logic            drain_cnt;
  logic            start_ok;
  logic            stall_en;
  logic            flush_en;

  assign start_ok = start && (state == ST_IDLE || state == ST_HALTED);
  assign stall_en = (state == ST_RUN) && bus.dhazard;
  assign flush_en = (state == ST_RUN) && !bus.dhazard && bus.chazard;

  assign bus.imem_addr = pc;
  assign bus.ifir      = ifir;
  assign bus.idir      = idir;
  assign bus.exir      = exir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ifir      <= NOP;
      idir      <= NOP;
      exir      <= NOP;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start_ok) begin
            state <= ST_RUN;
            pc    <= start_pc;
            ifir  <= NOP;
            idir  <= NOP;
            exir  <= NOP;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.dhazard) begin
            idir <= NOP;
            exir <= idir;
          end else if (bus.chazard) begin
            // Absolute branch target comes from the branch sitting in IF.
            pc   <= ifir[PC_W-1:0];
            ifir <= NOP;
            idir <= ifir;
            exir <= idir;
          end else begin
            idir <= ifir;
            exir <= idir;
            if (bus.imem_data == HALT) begin
              ifir      <= NOP;
              state     <= ST_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              ifir <= bus.imem_data;
              pc   <= pc + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          ifir <= NOP;
          idir <= NOP;
          exir <= idir;
          if (drain_cnt) begin
            state <= ST_HALTED;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .clr (start_ok),
    .cnt (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_en),
    .clr (start_ok),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer with a behavioural
// instruction memory and hand-computed expectations.
module tb_pipe_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        busy, done;
  logic [15:0] stall_cnt, flush_cnt;
  logic [15:0] imem [0:255];

  int checks = 0;
  int errors = 0;

  pipe_sequencer_if #(.PC_W(8)) bus ();

  assign bus.imem_data = imem[bus.imem_addr];

  pipe_sequencer #(.PC_W(8), .NOP(16'h0000), .HALT(16'h3FFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_pc  (start_pc),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifir, bus.idir, bus.exir} !== {8'h00, 48'h0}) begin
      errors++;
      $display("FAIL reset_regs: got %h want %h", {bus.imem_addr, bus.ifir, bus.idir, bus.exir}, {8'h00, 48'h0});
    end
    checks++;
    if ({busy, done, stall_cnt, flush_cnt} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_status: got %h want %h", {busy, done, stall_cnt, flush_cnt}, {2'b00, 32'h0});
    end
    rst = 1'b0;
    bus.dhazard = 1'b1;
    tick();
    bus.dhazard = 1'b0;
    checks++;
    if ({busy, stall_cnt, bus.imem_addr} !== {1'b0, 16'h0, 8'h00}) begin
      errors++;
      $display("FAIL idle_ignores_hazard: got %h want %h", {busy, stall_cnt, bus.imem_addr}, {1'b0, 16'h0, 8'h00});
    end
  endtask

  task automatic test_straight_line;
    start_pc = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, bus.imem_addr, bus.ifir} !== {2'b10, 8'd10, 16'h0000}) begin
      errors++;
      $display("FAIL start_edge: got %h want %h", {busy, done, bus.imem_addr, bus.ifir}, {2'b10, 8'd10, 16'h0000});
    end
    tick();
    checks++;
    if ({bus.ifir, bus.imem_addr} !== {16'h4120, 8'd11}) begin
      errors++;
      $display("FAIL line_cycle1: got %h want %h", {bus.ifir, bus.imem_addr}, {16'h4120, 8'd11});
    end
    tick();
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifir, bus.idir, bus.exir} !== {8'd13, 16'h4360, 16'h8240, 16'h4120}) begin
      errors++;
      $display("FAIL line_cycle3: got %h want %h", {bus.imem_addr, bus.ifir, bus.idir, bus.exir}, {8'd13, 16'h4360, 16'h8240, 16'h4120});
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL line_counters: got %h want %h", {stall_cnt, flush_cnt}, 32'h0);
    end
  endtask

  task automatic test_stall;
    tick();
    checks++;
    if ({bus.ifir, bus.imem_addr} !== {16'hC0AA, 8'd14}) begin
      errors++;
      $display("FAIL stall_setup: got %h want %h", {bus.ifir, bus.imem_addr}, {16'hC0AA, 8'd14});
    end
    bus.dhazard = 1'b1;
    tick();
    bus.dhazard = 1'b0;
    checks++;
    if ({bus.imem_addr, bus.ifir, bus.idir, bus.exir} !== {8'd14, 16'hC0AA, 16'h0000, 16'h4360}) begin
      errors++;
      $display("FAIL stall_regs: got %h want %h", {bus.imem_addr, bus.ifir, bus.idir, bus.exir}, {8'd14, 16'hC0AA, 16'h0000, 16'h4360});
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== {16'd1, 16'd0}) begin
      errors++;
      $display("FAIL stall_count: got %h want %h", {stall_cnt, flush_cnt}, {16'd1, 16'd0});
    end
  endtask

  task automatic test_redirect;
    tick();
    bus.chazard = 1'b1;
    tick();
    bus.chazard = 1'b0;
    checks++;
    if ({bus.imem_addr, bus.ifir, bus.idir, bus.exir} !== {8'h25, 16'h0000, 16'hC025, 16'hC0AA}) begin
      errors++;
      $display("FAIL redirect_regs: got %h want %h", {bus.imem_addr, bus.ifir, bus.idir, bus.exir}, {8'h25, 16'h0000, 16'hC025, 16'hC0AA});
    end
    checks++;
    if ({busy, done, stall_cnt, flush_cnt} !== {2'b10, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL redirect_status: got %h want %h", {busy, done, stall_cnt, flush_cnt}, {2'b10, 16'd1, 16'd1});
    end
    tick();
    checks++;
    if ({bus.ifir, bus.imem_addr, bus.exir} !== {16'h4BCD, 8'h26, 16'hC025}) begin
      errors++;
      $display("FAIL redirect_target: got %h want %h", {bus.ifir, bus.imem_addr, bus.exir}, {16'h4BCD, 8'h26, 16'hC025});
    end
  endtask

  task automatic test_start_in_run;
    start_pc = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({bus.ifir, bus.imem_addr, busy, stall_cnt, flush_cnt} !== {16'hC014, 8'h27, 1'b1, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL start_ignored: got %h want %h", {bus.ifir, bus.imem_addr, busy, stall_cnt, flush_cnt}, {16'hC014, 8'h27, 1'b1, 16'd1, 16'd1});
    end
  endtask

  task automatic test_halt_drain;
    bus.chazard = 1'b1;
    tick();
    bus.chazard = 1'b0;
    checks++;
    if ({bus.imem_addr, flush_cnt} !== {8'd20, 16'd2}) begin
      errors++;
      $display("FAIL branch_to_halt: got %h want %h", {bus.imem_addr, flush_cnt}, {8'd20, 16'd2});
    end
    tick();
    checks++;
    if ({bus.imem_addr, busy, done, bus.exir} !== {8'd20, 2'b10, 16'hC014}) begin
      errors++;
      $display("FAIL drain_entry: got %h want %h", {bus.imem_addr, busy, done, bus.exir}, {8'd20, 2'b10, 16'hC014});
    end
    tick();
    checks++;
    if ({bus.imem_addr, busy, done} !== {8'd20, 2'b10}) begin
      errors++;
      $display("FAIL drain_second: got %h want %h", {bus.imem_addr, busy, done}, {8'd20, 2'b10});
    end
    tick();
    checks++;
    if ({bus.imem_addr, busy, done, bus.ifir, bus.idir, bus.exir} !== {8'd20, 2'b01, 48'h0}) begin
      errors++;
      $display("FAIL halted: got %h want %h", {bus.imem_addr, busy, done, bus.ifir, bus.idir, bus.exir}, {8'd20, 2'b01, 48'h0});
    end
    bus.dhazard = 1'b1;
    tick();
    bus.dhazard = 1'b0;
    checks++;
    if ({done, stall_cnt, bus.imem_addr} !== {1'b1, 16'd1, 8'd20}) begin
      errors++;
      $display("FAIL halted_holds: got %h want %h", {done, stall_cnt, bus.imem_addr}, {1'b1, 16'd1, 8'd20});
    end
  endtask

  task automatic test_restart;
    start_pc = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, bus.imem_addr, stall_cnt, flush_cnt} !== {2'b10, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL restart: got %h want %h", {busy, done, bus.imem_addr, stall_cnt, flush_cnt}, {2'b10, 8'h00, 32'h0});
    end
  endtask

  task automatic test_reset_mid_drain;
    bus.dhazard = 1'b1;
    tick();
    bus.dhazard = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, bus.idir, stall_cnt, bus.imem_addr} !== {2'b10, 16'h1234, 16'd1, 8'd1}) begin
      errors++;
      $display("FAIL drain_before_reset: got %h want %h", {busy, done, bus.idir, stall_cnt, bus.imem_addr}, {2'b10, 16'h1234, 16'd1, 8'd1});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bus.imem_addr, bus.ifir, bus.idir, bus.exir, stall_cnt, flush_cnt} !== {2'b00, 8'h00, 80'h0}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", {busy, done, bus.imem_addr, bus.ifir, bus.idir, bus.exir, stall_cnt, flush_cnt}, {2'b00, 8'h00, 80'h0});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saturation;
    start_pc = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.dhazard = 1'b1;
    repeat (65534) tick();
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_below: got %h want %h", stall_cnt, 16'hFFFE);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h want %h", stall_cnt, 16'hFFFF);
    end
    repeat (4465) tick();
    bus.dhazard = 1'b0;
    checks++;
    if ({stall_cnt, flush_cnt, bus.imem_addr} !== {16'hFFFF, 16'h0, 8'h40}) begin
      errors++;
      $display("FAIL sat_hold: got %h want %h", {stall_cnt, flush_cnt, bus.imem_addr}, {16'hFFFF, 16'h0, 8'h40});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0]     = 16'h1234;
    imem[1]     = 16'h3FFF;
    imem[10]    = 16'h4120;
    imem[11]    = 16'h8240;
    imem[12]    = 16'h4360;
    imem[13]    = 16'hC0AA;
    imem[14]    = 16'hC025;
    imem[15]    = 16'h3FFF;
    imem[20]    = 16'h3FFF;
    imem[8'h25] = 16'h4BCD;
    imem[8'h26] = 16'hC014;
    bus.dhazard = 1'b0;
    bus.chazard = 1'b0;

    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_start_in_run();
    test_halt_drain();
    test_restart();
    test_reset_mid_drain();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
